psum_acc_buf: RTL and testbench
===============================

PSUM_ACC_BUF -- requirements
Module: psum_acc_buf

Interface
REQ-001 The module SHALL expose the following parameters, one per line as name, default, meaning:
  WIDTH  32  signed lane width, matching the downstream relu lane width
  DEPTH  64  number of lanes per packed vector
  CNT_W  8   width of the beat counter
REQ-002 The module SHALL expose the following ports, one per line as name, direction, width, meaning:
  clk        in   1            single clock, rising edge
  rst        in   1            asynchronous, active-high reset
  in_valid   in   1            input beat valid
  in_ready   out  1            input beat accepted when in_valid && in_ready
  in_first   in   1            beat opens a new accumulation group
  in_last    in   1            beat closes the current group
  in_data    in   WIDTH*DEPTH  packed signed partial sums, lane i at [WIDTH*i +: WIDTH]
  out_valid  out  1            packed result valid
  out_ready  in   1            consumer accepts when out_valid && out_ready
  out_data   out  WIDTH*DEPTH  packed accumulated sums, feeds relu buf_data directly
  out_beats  out  CNT_W        beats in the emitted group, saturating
  err        out  1            sticky protocol-error flag
REQ-003 Clock and reset SHALL be fixed as: one clock (clk); asynchronous, active-high reset (rst).

Function
REQ-004 FSM states SHALL be IDLE (no open group) and ACCUM (group open).
REQ-005 in_ready SHALL be driven as (!out_valid || out_ready), combinationally.
REQ-006 An accepted beat with in_first=1 SHALL load acc lanes with in_data and set beat count to 1, regardless of state.
REQ-007 An accepted beat with in_first=0 in ACCUM SHALL update each lane as acc = sat(acc + in_data) and increment the beat count, saturating at 2^CNT_W-1.
REQ-008 Per-lane addition SHALL be signed, WIDTH+1-bit intermediate, saturating to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-009 An accepted beat with in_first=0 in IDLE SHALL be treated as in_first=1 and SHALL set err=1.
REQ-010 Transitions SHALL be: IDLE->ACCUM on an accepted beat with in_last=0; ACCUM->IDLE on an accepted beat with in_last=1; otherwise the state is held.
REQ-011 An accepted beat with in_last=1 SHALL register the post-update accumulator into out_data and the post-update count into out_beats, with out_valid=1 on the next cycle (latency 1 cycle).
REQ-012 A beat with in_first=1 and in_last=1 SHALL produce out_data = in_data and out_beats = 1 one cycle later, leaving the state in IDLE.
REQ-013 out_valid SHALL clear on out_valid && out_ready unless a new last beat is accepted in the same cycle, in which case out_data is replaced and out_valid stays 1.
REQ-014 out_data and out_beats SHALL be stable while out_valid && !out_ready.
REQ-015 The accumulator SHALL be unaffected by output-side stalls; only input acceptance is gated.
REQ-016 err SHALL be sticky until reset.

Reset
REQ-017 While rst=1, the module SHALL hold: state=IDLE, all accumulator lanes=0, beat count=0, out_data=0, out_beats=0, out_valid=0, err=0.
REQ-018 Asserting rst mid-group SHALL discard the partial accumulation; the first accepted beat after reset without in_first SHALL set err.

Structure
REQ-019 A shared package SHALL hold the FSM state typedef (IDLE, ACCUM) and the saturation bound constants, as functions of WIDTH.
REQ-020 One sub-module, sat_add_lane (a WIDTH-bit signed saturating adder), SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=4)
REQ-021 Beats {first}[1,2,3,4], [10,10,10,10], {last}[-5,0,5,-20] -> out_data [6,12,18,-6], out_beats=3, err=0.
REQ-022 Beats {first}[100,-100,0,0], {last}[100,-100,1,-1] -> out_data [127,-128,1,-1].
REQ-023 Single {first,last} beat [7,-7,0,3] -> out_data [7,-7,0,3] one cycle later, out_beats=1, state IDLE.
REQ-024 out_ready held 0 with out_valid=1, next last beat offered -> in_ready=0 and out_data unchanged; out_ready=1 with a concurrent last beat -> out_valid stays 1 and out_data is replaced.
REQ-025 After reset, a beat with in_first=0 [2,2,2,2] then a last beat [1,1,1,1] -> err=1, out_data [3,3,3,3].
REQ-026 rst pulsed between two beats of a group -> all outputs 0 immediately; no out_valid from the aborted group.

Source files
------------

// File: rtl/psum_acc_buf_pkg.sv
// Shared types and saturation bounds for the partial-sum accumulation buffer.
// Bounds are computed as functions of lane width so every lane agrees on them.
package psum_acc_buf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int SAT_CALC_W = 64;

  function automatic logic signed [SAT_CALC_W-1:0] sat_hi(input int w);
    logic signed [SAT_CALC_W-1:0] one;
    one = 64'sd1;
    return (one <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_CALC_W-1:0] sat_lo(input int w);
    logic signed [SAT_CALC_W-1:0] one;
    one = 64'sd1;
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/psum_acc_buf_sat_add_lane.sv
// One accumulator lane: signed WIDTH-bit add through a WIDTH+1-bit intermediate,
// clamped to the representable signed range.
module sat_add_lane
  import psum_acc_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_y
);

  localparam logic signed [WIDTH-1:0] SAT_HI = WIDTH'(sat_hi(WIDTH));
  localparam logic signed [WIDTH-1:0] SAT_LO = WIDTH'(sat_lo(WIDTH));

  // Overflow shows up as disagreement between the two top bits of the wide sum.
  function automatic logic signed [WIDTH-1:0] sat_f(input logic signed [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1]) begin
      return s[WIDTH] ? SAT_LO : SAT_HI;
    end
    return s[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] w_sum;

  assign w_sum = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
  assign o_y   = sat_f(w_sum);

endmodule

// File: rtl/psum_acc_buf.sv
// Accumulates packed signed partial-sum beats into a group total and hands the
// finished vector to a single-entry output register with valid/ready handshake.
module psum_acc_buf
  import psum_acc_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*DEPTH-1:0] out_data,
  output logic [CNT_W-1:0]       out_beats,
  output logic                   err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH*DEPTH-1:0] r_acc;
  logic [WIDTH*DEPTH-1:0] w_sum;
  logic [WIDTH*DEPTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [WIDTH*DEPTH-1:0] r_out_data;
  logic [CNT_W-1:0]       r_out_beats;
  logic                   r_out_valid;
  logic                   r_err;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_orphan;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    sat_add_lane #(.WIDTH(WIDTH)) u_add (
      .i_a (r_acc[WIDTH*g +: WIDTH]),
      .i_b (in_data[WIDTH*g +: WIDTH]),
      .o_y (w_sum[WIDTH*g +: WIDTH])
    );
  end

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A continuation beat with no open group is restarted as a fresh group.
  assign w_orphan  = !in_first && (r_state == IDLE);
  assign w_load    = in_first || (r_state == IDLE);
  assign w_acc_nxt = w_load ? in_data : w_sum;
  assign w_cnt_nxt = w_load ? CNT_W'(1)
                   : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = in_last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        if (w_orphan) r_err <= 1'b1;
      end
    end
  end

  // Output register: a new closing beat may overwrite the entry in the same
  // cycle it is consumed, keeping valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && in_last) begin
      r_out_data  <= w_acc_nxt;
      r_out_beats <= w_cnt_nxt;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign err       = r_err;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Directed bench for psum_acc_buf at WIDTH=8, DEPTH=4 with hand-computed vectors.
module tb_psum_acc_buf;
  import psum_acc_buf_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_first = 1'b0;
  logic                   in_last = 1'b0;
  logic [WIDTH*DEPTH-1:0] in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [WIDTH*DEPTH-1:0] out_data;
  logic [CNT_W-1:0]       out_beats;
  logic                   err;

  int checks = 0;
  int errors = 0;

  psum_acc_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Offer one beat for one clock; caller guarantees in_ready is high.
  task automatic beat(input logic f, input logic l, input logic [31:0] d);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    checks++;
    if (out_beats !== 8'd0) begin errors++; $display("FAIL reset_out_beats got %0d want 0", out_beats); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_accum();
    out_ready = 1'b1;
    beat(1'b1, 1'b0, pk(1, 2, 3, 4));
    beat(1'b0, 1'b0, pk(10, 10, 10, 10));
    beat(1'b0, 1'b1, pk(-5, 0, 5, -20));
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL accum_valid got %0b want 1", out_valid); end
    checks++;
    if (out_data !== pk(6, 12, 18, -6)) begin errors++; $display("FAIL accum_data got %h want %h", out_data, pk(6, 12, 18, -6)); end
    checks++;
    if (out_beats !== 8'd3) begin errors++; $display("FAIL accum_beats got %0d want 3", out_beats); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL accum_err got %0b want 0", err); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL accum_valid_clear got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    beat(1'b1, 1'b0, pk(100, -100, 0, 0));
    beat(1'b0, 1'b1, pk(100, -100, 1, -1));
    checks++;
    if (out_data !== pk(127, -128, 1, -1)) begin errors++; $display("FAIL sat_data got %h want %h", out_data, pk(127, -128, 1, -1)); end
    checks++;
    if (out_beats !== 8'd2) begin errors++; $display("FAIL sat_beats got %0d want 2", out_beats); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    beat(1'b1, 1'b1, pk(7, -7, 0, 3));
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++;
    if (out_data !== pk(7, -7, 0, 3)) begin errors++; $display("FAIL single_data got %h want %h", out_data, pk(7, -7, 0, 3)); end
    checks++;
    if (out_beats !== 8'd1) begin errors++; $display("FAIL single_beats got %0d want 1", out_beats); end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL single_state got %0d want IDLE", dut.r_state); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(1'b1, 1'b1, pk(1, 1, 1, 1));
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_data  = pk(2, 2, 2, 2);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0b want 1", out_valid); end
    checks++;
    if (out_data !== pk(1, 1, 1, 1)) begin errors++; $display("FAIL bp_hold_data got %h want %h", out_data, pk(1, 1, 1, 1)); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_replace_valid got %0b want 1", out_valid); end
    checks++;
    if (out_data !== pk(2, 2, 2, 2)) begin errors++; $display("FAIL bp_replace_data got %h want %h", out_data, pk(2, 2, 2, 2)); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_err_after_reset();
    apply_reset();
    beat(1'b0, 1'b0, pk(2, 2, 2, 2));
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL orphan_err got %0b want 1", err); end
    beat(1'b0, 1'b1, pk(1, 1, 1, 1));
    checks++;
    if (out_data !== pk(3, 3, 3, 3)) begin errors++; $display("FAIL orphan_data got %h want %h", out_data, pk(3, 3, 3, 3)); end
    checks++;
    if (out_beats !== 8'd2) begin errors++; $display("FAIL orphan_beats got %0d want 2", out_beats); end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky got %0b want 1", err); end
  endtask

  task automatic test_reset_mid_group();
    int seen;
    beat(1'b1, 1'b1, pk(9, 9, 9, 9));
    beat(1'b1, 1'b0, pk(5, 6, 7, 8));
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %0b want 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL abort_data got %h want 00000000", out_data); end
    checks++;
    if (out_beats !== 8'd0) begin errors++; $display("FAIL abort_beats got %0d want 0", out_beats); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL abort_err got %0b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    beat(1'b0, 1'b1, pk(1, 2, 3, 4));
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL abort_orphan_err got %0b want 1", err); end
    checks++;
    if (out_data !== pk(1, 2, 3, 4)) begin errors++; $display("FAIL abort_fresh_data got %h want %h", out_data, pk(1, 2, 3, 4)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cnt_sat();
    apply_reset();
    beat(1'b1, 1'b0, pk(0, 0, 0, 0));
    for (int i = 0; i < 299; i++) beat(1'b0, 1'b0, pk(0, 0, 0, 0));
    beat(1'b0, 1'b1, pk(1, 0, 0, 0));
    checks++;
    if (out_beats !== 8'd255) begin errors++; $display("FAIL cnt_sat_beats got %0d want 255", out_beats); end
    checks++;
    if (out_data !== pk(1, 0, 0, 0)) begin errors++; $display("FAIL cnt_sat_data got %h want %h", out_data, pk(1, 0, 0, 0)); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_accum();
    test_saturation();
    test_single();
    test_backpressure();
    test_err_after_reset();
    test_reset_mid_group();
    test_cnt_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
